// File: rtl/norm_32bit.sv
// Iterative left-normalizer: shifts a word by at most STEP bits per cycle until its MSB reaches bit 31.
// Optional build macro NORM_POS_CHECK_EN adds pos_err, flagging an input_pos that disagrees with input_num.
module norm_32bit #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_num,
  input  logic [5:0]  input_pos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] output_mant,
  output logic [4:0]  output_exp,
  output logic        output_zero
`ifdef NORM_POS_CHECK_EN
  ,
  output logic        pos_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] work_q;
  logic [5:0]  rem_q;
  logic [4:0]  exp_q;
  logic        zero_q;

  logic        pos_zero_d;
  logic        pos_full_d;
  logic [5:0]  rem_init_d;
  logic [4:0]  exp_init_d;
  logic [5:0]  shift_amt_d;
  logic [31:0] work_shift_d;
  logic [5:0]  rem_next_d;

  // Positions above 32 are illegal and collapse onto the zero-word result.
  always_comb begin
    pos_zero_d = (input_pos == 6'd0) || (input_pos > 6'd32);
    pos_full_d = (input_pos == 6'd32);
    rem_init_d = 6'd32 - input_pos;
    exp_init_d = 5'(input_pos - 6'd1);
  end

  always_comb begin
    shift_amt_d  = (rem_q < STEP_W) ? rem_q : STEP_W;
    work_shift_d = work_q << shift_amt_d;
    rem_next_d   = rem_q - shift_amt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      work_q      <= 32'd0;
      rem_q       <= 6'd0;
      exp_q       <= 5'd0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (pos_zero_d) begin
              work_q      <= 32'd0;
              rem_q       <= 6'd0;
              exp_q       <= 5'd0;
              zero_q      <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              work_q <= input_num;
              rem_q  <= rem_init_d;
              exp_q  <= exp_init_d;
              zero_q <= 1'b0;
              if (pos_full_d) begin
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                state_q <= SHIFT;
              end
            end
          end
        end
        SHIFT: begin
          work_q <= work_shift_d;
          rem_q  <= rem_next_d;
          if (rem_next_d == 6'd0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign output_mant = work_q;
  assign output_exp  = exp_q;
  assign output_zero = zero_q;

`ifdef NORM_POS_CHECK_EN
  logic [5:0] true_pos_d;
  logic       pos_err_q;

  always_comb begin
    true_pos_d = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (input_num[i]) true_pos_d = 6'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_err_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      pos_err_q <= (true_pos_d != input_pos);
    end
  end

  assign pos_err = pos_err_q;
`endif

endmodule

// File: tb/tb_norm_32bit.sv
// Directed-vector bench for norm_32bit (STEP=8) with hand-computed mantissa, exponent and latency.
module tb_norm_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_num;
  logic [5:0]  input_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] output_mant;
  logic [4:0]  output_exp;
  logic        output_zero;
`ifdef NORM_POS_CHECK_EN
  logic        pos_err;
`endif

  int n_checks;
  int n_fail;

  norm_32bit #(.STEP(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_num   (input_num),
    .input_pos   (input_pos),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_mant (output_mant),
    .output_exp  (output_exp),
    .output_zero (output_zero)
`ifdef NORM_POS_CHECK_EN
    ,
    .pos_err     (pos_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one word for a single accept edge; leaves the bench just after that edge.
  task automatic accept(input logic [31:0] num, input logic [5:0] pos);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    input_num = num;
    input_pos = pos;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    input_num = 32'hDEAD_BEEF;
    input_pos = 6'd0;
  endtask

  // Counts cycles from the accept edge to the first out_valid and checks the result fields.
  task automatic expect_result(input string name, input int exp_lat, input logic [31:0] exp_mant,
                               input logic [4:0] exp_exp, input logic exp_zero);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_mant"}, output_mant, exp_mant);
    check({name, "_exp"}, 32'(output_exp), 32'(exp_exp));
    check({name, "_zero"}, 32'(output_zero), 32'(exp_zero));
    $display("txn %s: lat=%0d mant=0x%08h exp=%0d zero=%0b", name, lat, output_mant, output_exp, output_zero);
  endtask

  // With out_ready held high the DONE cycle handshakes at the next edge.
  task automatic finish_handshake(input string name);
    @(posedge clk);
    #1;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] num, input logic [5:0] pos,
                        input int exp_lat, input logic [31:0] exp_mant, input logic [4:0] exp_exp,
                        input logic exp_zero);
    accept(num, pos);
    expect_result(name, exp_lat, exp_mant, exp_exp, exp_zero);
    finish_handshake(name);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    input_num = 32'd0;
    input_pos = 6'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_mant", output_mant, 32'd0);
    check("reset_exp", 32'(output_exp), 32'd0);
    check("reset_zero", 32'(output_zero), 32'd0);

    run_op("pos1", 32'h0000_0001, 6'd1, 5, 32'h8000_0000, 5'd0, 1'b0);
    run_op("pos32", 32'h8000_0000, 6'd32, 1, 32'h8000_0000, 5'd31, 1'b0);
    run_op("zero", 32'h0000_0000, 6'd0, 1, 32'h0000_0000, 5'd0, 1'b1);
    run_op("pos40", 32'h0000_0000, 6'd40, 1, 32'h0000_0000, 5'd0, 1'b1);
    run_op("pos8", 32'h0000_00F0, 6'd8, 4, 32'hF000_0000, 5'd7, 1'b0);
    run_op("pos24", 32'h00AB_CDEF, 6'd24, 2, 32'hABCD_EF00, 5'd23, 1'b0);

    // Backpressure: result must hold, and in_valid during DONE must be ignored.
    out_ready = 1'b0;
    accept(32'h0001_2345, 6'd17);
    expect_result("bp", 3, 32'h91A2_8000, 5'd16, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        in_valid  = 1'b1;
        input_num = 32'hFFFF_FFFF;
        input_pos = 6'd32;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_mant", output_mant, 32'h91A2_8000);
      check("bp_hold_exp", 32'(output_exp), 32'd16);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_handshake("bp");

    // Reset during the second SHIFT cycle must discard the operation.
    accept(32'h0000_0001, 6'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_mant", output_mant, 32'd0);
    check("midrst_exp", 32'(output_exp), 32'd0);
    check("midrst_zero", 32'(output_zero), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst_no_result", 32'(seen), 32'd0);
    end
    $display("txn midrst: operation discarded");
    run_op("after_rst", 32'h0000_0100, 6'd9, 4, 32'h8000_0000, 5'd8, 1'b0);

`ifdef NORM_POS_CHECK_EN
    // Wrong position: 0xF0 << 27 leaves only bit 31 set.
    accept(32'h0000_00F0, 6'd5);
    expect_result("poserr_bad", 5, 32'h8000_0000, 5'd4, 1'b0);
    check("poserr_bad_flag", 32'(pos_err), 32'd1);
    finish_handshake("poserr_bad");
    accept(32'h0000_00F0, 6'd8);
    expect_result("poserr_ok", 4, 32'hF000_0000, 5'd7, 1'b0);
    check("poserr_ok_flag", 32'(pos_err), 32'd0);
    finish_handshake("poserr_ok");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
